// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID pipeline register.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        remain_pc,
  input  logic        branch,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] redir_tgt;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  assign br_off = {{14{id_instr[15]}},
                   id_instr[15:0], 2'b00};
  assign br_tgt = id_pc4 + br_off;
  assign j_tgt  = {id_pc4[31:28],
                   id_instr[25:0], 2'b00};
  assign jr_tgt = {jr_target[31:2], 2'b00};

  // Redirect target: jr over jump over branch.
  always_comb begin
    redir_tgt = br_tgt;
    unique case (1'b1)
      jr:      redir_tgt = jr_tgt;
      jump:    redir_tgt = j_tgt;
      default: redir_tgt = br_tgt;
    endcase
  end

  // PC and IF/ID: reset, hold, squash-and-redirect, or advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      id_instr <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else if (remain_pc) begin
      pc       <= pc;
      id_instr <= id_instr;
      id_pc4   <= id_pc4;
      id_valid <= id_valid;
    end else if (branch) begin
      pc       <= redir_tgt;
      id_instr <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      pc       <= pc_plus4;
      id_instr <= imem_rdata;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_q;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Count advances, holds and redirects with the same priority as the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 32'd0;
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else if (remain_pc) begin
      stall_q <= stall_q + 32'd1;
    end else if (branch) begin
      flush_q <= flush_q + 32'd1;
    end else begin
      fetch_q <= fetch_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined CPU. It owns the PC, computes the next PC from the redirect decisions made by the ID-stage control unit (branch, jump, jr), and obeys the stall/hold signals that unit raises. It presents the instruction-memory address and hands the fetched instruction and its PC+4 to the ID stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- remain_pc  input  1  load-use hazard: hold PC and IF/ID register
- branch  input  1  redirect taken this cycle (taken beq/bne, j, jal, jr)
- jump  input  1  redirect is j/jal (pseudo-direct target)
- jr  input  1  redirect is jr (register target)
- jr_target  input  32  forwarded rs value from ID
- imem_rdata  input  32  instruction word at imem_addr, combinational read
- imem_addr  output  32  equals pc
- pc  output  32  current fetch PC
- id_instr  output  32  IF/ID instruction register
- id_pc4  output  32  IF/ID PC+4 register
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- fetch_cnt, stall_cnt, flush_cnt  output  32 each  performance counters (see Configuration)

## Operation
- Redirect targets, computed from IF/ID contents:
  - branch target = id_pc4 + ({{14{id_instr[15]}}, id_instr[15:0], 2'b00}), mod 2^32.
  - jump target = {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - jr target = {jr_target[31:2], 2'b00}; low bits are forced, never faulted.
  - Select: jr ? jr target : jump ? jump target : branch target.
- Per-cycle update, priority order:
  1. rst: pc <= RESET_PC; id_instr <= 0; id_pc4 <= 0; id_valid <= 0; counters <= 0.
  2. remain_pc: pc, id_instr, id_pc4, id_valid all hold. This applies even when branch=1 in the same cycle; the redirect re-evaluates next cycle.
  3. branch: pc <= selected target; id_instr <= 0 (nop); id_pc4 <= 0; id_valid <= 0. The instruction fetched this cycle is squashed. There is no delay slot.
  4. otherwise: pc <= pc + 4 (wraps at 2^32); id_instr <= imem_rdata; id_pc4 <= pc + 4; id_valid <= 1.
- No FSM beyond the PC. The pipeline state is fully captured by pc, IF/ID and id_valid.

## Timing
- All outputs are registered except imem_addr, which is wired to pc.
- Reset values: pc = RESET_PC, id_instr = 0, id_pc4 = 0, id_valid = 0, counters = 0.
- Instruction at PC X appears on id_instr in the cycle after pc = X, provided that cycle's edge was not hold or redirect.
- Redirect penalty is exactly 1 bubble: the cycle after branch=1 has pc = target and id_valid = 0. The target's instruction reaches ID one cycle later.
- Load-use hold: each cycle with remain_pc=1 freezes the stage; the bubble into EXE is inserted downstream, not here.
- Inputs are sampled only at the rising edge. Redirect inputs are don't-care while id_valid=0. Rising rst mid-stream aborts everything on the next edge.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_cnt increments on every normal advance.
  - stall_cnt increments on every remain_pc hold.
  - flush_cnt increments on every branch redirect.
  - All three are 32-bit and wrap modulo 2^32.
- IF_PERF_CNT_EN undefined: the counter ports remain present and are tied to 0; no counter flops are instantiated.

## Test plan
- Reset then free run, imem word = address: pc goes 0,4,8,12; id_instr lags pc by one cycle; id_pc4 = id_instr + 4; id_valid = 1 from the second edge.
- beq with id_pc4=0x10, imm=0xFFFE, branch=1: next pc = 0x08, id_valid = 0 for one cycle, then id_instr = word at 0x08.
- j with id_pc4=0x8000_0010, instr[25:0]=0x40: next pc = 0x8000_0100. jr with jr_target=0x0000_0203: next pc = 0x0000_0200.
- remain_pc held 2 cycles together with branch=1 on the first: pc and IF/ID frozen both cycles; the redirect takes effect on the first edge after remain_pc drops.
- pc=0xFFFF_FFFC, normal advance: pc = 0 and id_pc4 = 0 (wrap).
- With IF_PERF_CNT_EN, 5 advances + 2 holds + 1 redirect then rst: counters read 5/2/1, then all 0 after rst; without the macro all counters read 0 throughout.
